// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a byte-addressable memory: accept -> resp in N+1 cycles (1 on error); req_ready only in IDLE, response held until resp_ready.
// Define MEM_ACCESS_MISALIGNED_EN to execute misaligned half/word accesses as byte beats instead of flagging them.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic                  mem_is32bitWrite,
  output logic [7:0]            mem_wdata8,
  output logic [31:0]           mem_wdata32,
  input  logic [7:0]            mem_rdata8,
  input  logic [31:0]           mem_rdata32
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, raw_q, raw_next, rdata_q;
  logic [1:0]            size_q, beat_q, last_q, req_last;
  logic                  write_q, uns_q, word_q, err_q;
  logic [ADDR_WIDTH:0]   end_addr;
  logic [2:0]            nbytes;
  logic                  misaligned, req_err, req_word, last_beat, in_access;

  // Request checks; end address is one bit wider so a top-of-space access cannot wrap.
  always_comb begin
    case (req_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(nbytes);
`ifdef MEM_ACCESS_MISALIGNED_EN
    misaligned = 1'b0;
`else
    misaligned = (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`endif
    req_err  = (req_size == 2'd3) || (end_addr > MEM_LIMIT) || misaligned;
    req_word = (req_size == 2'd2) && (req_addr[1:0] == 2'b00);
    case (req_size)
      2'd0:    req_last = 2'd0;
      2'd1:    req_last = 2'd1;
      default: req_last = req_word ? 2'd0 : 2'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign last_beat = (beat_q == last_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (last_beat) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Merge the current beat's read data into the partially assembled word.
  always_comb begin
    raw_next = raw_q;
    if (word_q) raw_next = mem_rdata32;
    else        raw_next[{beat_q, 3'b000} +: 8] = mem_rdata8;
  end

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'd0:    extend = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    extend = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          write_q <= req_write;
          uns_q   <= req_unsigned;
          err_q   <= req_err;
          word_q  <= req_word;
          last_q  <= req_last;
          beat_q  <= '0;
          raw_q   <= '0;
          rdata_q <= '0;
        end
        ACCESS: begin
          raw_q  <= raw_next;
          beat_q <= beat_q + 2'd1;
          if (last_beat && !write_q) rdata_q <= extend(raw_next, size_q, uns_q);
        end
        default: ;
      endcase
    end
  end

  assign in_access  = (state == ACCESS);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_error = resp_valid & err_q;
  assign resp_rdata = rdata_q;

  // Write strobe is cut combinationally by reset so an interrupted access leaves no partial beat.
  assign mem_addr         = in_access ? addr_q + ADDR_WIDTH'(beat_q) : '0;
  assign mem_write_enable = in_access & write_q & ~reset;
  assign mem_is32bitWrite = in_access & write_q & word_q;
  assign mem_wdata32      = (in_access & write_q & word_q) ? wdata_q : '0;
  assign mem_wdata8       = (in_access & write_q & ~word_q) ? wdata_q[{beat_q, 3'b000} +: 8] : 8'd0;

endmodule
